// File: rtl/tmds_pkg.sv
// Shared constants and types for the TMDS frame receiver: control tokens,
// lock-state encoding and default 720p geometry.
package tmds_pkg;

    localparam logic [9:0] CTRL_00 = 10'b1101010100;
    localparam logic [9:0] CTRL_01 = 10'b0010101011;
    localparam logic [9:0] CTRL_10 = 10'b0101010100;
    localparam logic [9:0] CTRL_11 = 10'b1010101011;

    localparam int DEFAULT_H_ACTIVE = 1280;
    localparam int DEFAULT_V_ACTIVE = 720;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } lock_state_t;

endpackage

// File: rtl/tmds_decoder.sv
// Combinational single-channel TMDS decoder: 10b word to 8b data or 2b
// control, with a flag telling which of the two the word is.
module tmds_decoder
    import tmds_pkg::*;
(
    input  logic [9:0] word,
    output logic [7:0] data,
    output logic [1:0] ctrl,
    output logic       is_ctrl
);

    logic [7:0] q;

    always_comb begin
        q       = word[9] ? ~word[7:0] : word[7:0];
        data    = '0;
        data[0] = q[0];
        for (int unsigned i = 1; i < 8; i++) begin
            data[i] = word[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
        end
    end

    always_comb begin
        is_ctrl = 1'b1;
        ctrl    = '0;
        case (word)
            CTRL_00: ctrl = 2'b00;
            CTRL_01: ctrl = 2'b01;
            CTRL_10: ctrl = 2'b10;
            CTRL_11: ctrl = 2'b11;
            default: is_ctrl = 1'b0;
        endcase
    end

endmodule

// File: rtl/tmds_frame_receiver.sv
// Three-channel TMDS receiver: decode register, output register with
// active-region counters, frame geometry checks and lock FSM.
module tmds_frame_receiver
    import tmds_pkg::*;
#(
    parameter int H_ACTIVE    = DEFAULT_H_ACTIVE,
    parameter int V_ACTIVE    = DEFAULT_V_ACTIVE,
    parameter int LOCK_FRAMES = 2
) (
    input  logic            clk_pixel,
    input  logic            rst_n_in,
    input  logic [2:0][9:0] tmds_in,
    output logic [7:0]      red_out,
    output logic [7:0]      green_out,
    output logic [7:0]      blue_out,
    output logic            de_out,
    output logic            hs_out,
    output logic            vs_out,
    output logic [10:0]     hcount_out,
    output logic [9:0]      vcount_out,
    output logic            new_frame_out,
    output logic            locked_out,
    output logic            err_out
);

    localparam logic [11:0] H_EXP  = 12'(H_ACTIVE);
    localparam logic [9:0]  V_EXP  = 10'(V_ACTIVE);
    localparam logic [7:0]  LOCK_N = 8'(LOCK_FRAMES);

    logic [7:0] dec_data [3];
    logic [1:0] dec_ctrl [3];
    logic [2:0] dec_is_ctrl;

    tmds_decoder u_dec_blue  (.word(tmds_in[0]), .data(dec_data[0]), .ctrl(dec_ctrl[0]), .is_ctrl(dec_is_ctrl[0]));
    tmds_decoder u_dec_green (.word(tmds_in[1]), .data(dec_data[1]), .ctrl(dec_ctrl[1]), .is_ctrl(dec_is_ctrl[1]));
    tmds_decoder u_dec_red   (.word(tmds_in[2]), .data(dec_data[2]), .ctrl(dec_ctrl[2]), .is_ctrl(dec_is_ctrl[2]));

    // Sync comes from the blue channel only.
    logic unused_ctrl;
    assign unused_ctrl = ^{dec_ctrl[1], dec_ctrl[2]};

    logic all_data, all_ctrl;
    assign all_data = ~|dec_is_ctrl;
    assign all_ctrl = &dec_is_ctrl;

    logic [7:0] s1_red, s1_green, s1_blue;
    logic       s1_de, s1_hs, s1_vs, s1_err;

    always_ff @(posedge clk_pixel or negedge rst_n_in) begin
        if (!rst_n_in) begin
            s1_red   <= '0;
            s1_green <= '0;
            s1_blue  <= '0;
            s1_de    <= 1'b0;
            s1_hs    <= 1'b0;
            s1_vs    <= 1'b0;
            s1_err   <= 1'b0;
        end else begin
            s1_de    <= all_data;
            s1_err   <= ~all_data & ~all_ctrl;
            s1_red   <= all_data ? dec_data[2] : '0;
            s1_green <= all_data ? dec_data[1] : '0;
            s1_blue  <= all_data ? dec_data[0] : '0;
            if (all_ctrl) begin
                s1_hs <= dec_ctrl[0][0];
                s1_vs <= dec_ctrl[0][1];
            end
        end
    end

    lock_state_t state, state_nx;
    logic [7:0]  good_cnt, good_nx;
    logic        frame_bad, frame_bad_nx;
    logic        armed, armed_nx;
    logic        de_rise, de_fall, vs_rise;
    logic        line_bad, frame_mis, new_frame_nx;
    logic [10:0] hcount_nx;
    logic [9:0]  vcount_line, vcount_nx;

    always_comb begin
        de_rise = s1_de & ~de_out;
        de_fall = ~s1_de & de_out;
        vs_rise = s1_vs & ~vs_out;

        hcount_nx = hcount_out;
        if (de_rise) begin
            hcount_nx = '0;
        end else if (s1_de && hcount_out != '1) begin
            hcount_nx = hcount_out + 11'd1;
        end

        // The finishing line is counted before the frame check sees vcount.
        vcount_line = vcount_out;
        if (de_fall && vcount_out != '1) begin
            vcount_line = vcount_out + 10'd1;
        end
        vcount_nx = vs_rise ? '0 : vcount_line;

        line_bad     = de_fall && (({1'b0, hcount_out} + 12'd1) != H_EXP);
        frame_mis    = vs_rise && (vcount_line != V_EXP);
        frame_bad_nx = vs_rise ? 1'b0 : (frame_bad | line_bad | s1_err);
        armed_nx     = vs_rise ? 1'b1 : (s1_de ? 1'b0 : armed);
        new_frame_nx = s1_de & armed;

        state_nx = state;
        good_nx  = good_cnt;
        case (state)
            SEARCH: begin
                if (vs_rise) begin
                    state_nx = MEASURE;
                    good_nx  = '0;
                end
            end
            MEASURE: begin
                if (vs_rise) begin
                    if (frame_bad | line_bad | s1_err | frame_mis) begin
                        state_nx = SEARCH;
                    end else begin
                        good_nx = good_cnt + 8'd1;
                        if (good_nx >= LOCK_N) state_nx = LOCKED;
                    end
                end
            end
            LOCKED: begin
                if (line_bad | s1_err | frame_mis) state_nx = SEARCH;
            end
            default: state_nx = SEARCH;
        endcase
    end

    always_ff @(posedge clk_pixel or negedge rst_n_in) begin
        if (!rst_n_in) begin
            red_out       <= '0;
            green_out     <= '0;
            blue_out      <= '0;
            de_out        <= 1'b0;
            hs_out        <= 1'b0;
            vs_out        <= 1'b0;
            err_out       <= 1'b0;
            new_frame_out <= 1'b0;
            hcount_out    <= '0;
            vcount_out    <= '0;
            frame_bad     <= 1'b0;
            armed         <= 1'b0;
            good_cnt      <= '0;
            state         <= SEARCH;
        end else begin
            red_out       <= s1_red;
            green_out     <= s1_green;
            blue_out      <= s1_blue;
            de_out        <= s1_de;
            hs_out        <= s1_hs;
            vs_out        <= s1_vs;
            err_out       <= s1_err;
            new_frame_out <= new_frame_nx;
            hcount_out    <= hcount_nx;
            vcount_out    <= vcount_nx;
            frame_bad     <= frame_bad_nx;
            armed         <= armed_nx;
            good_cnt      <= good_nx;
            state         <= state_nx;
        end
    end

    assign locked_out = (state == LOCKED);

endmodule
